normalize_shifter: RTL and testbench

- Consumer at the far end of the FindFirstOne index interface. Takes an operand plus its leading-one index and valid flag, and left-justifies the operand so the leading one lands in bit N-1.
- Reports the shift amount, which the fixed-point adder uses for exponent/scale adjust.
- Implemented as an iterative log-step shifter: one binary shift stage per clock, with valid/ready handshakes on both sides.

---
 rtl/normalize_shifter_pkg.sv | 36 +++
 rtl/normalize_shifter.sv | 144 ++++++++++++++
 tb/tb_normalize_shifter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/normalize_shifter_pkg.sv
// -----------------------------------------------------------------------------
// normalize_pkg
//   Shared definitions for the normalize shifter: default operand and index
//   widths, the controller state encoding, and the shift-amount helper that
//   both the datapath and any model of it use.
//
//   Contents:
//     N_DEFAULT            default operand width (power of two, >= 4)
//     INDEX_WIDTH_DEFAULT  default width of index / shift-amount fields
//     state_e              IDLE -> SHIFT -> DONE -> IDLE
//     calc_shamt()         left-shift amount that moves the leading one to
//                          the top bit, or zero for a zero operand
// -----------------------------------------------------------------------------
package normalize_pkg;

  localparam int unsigned N_DEFAULT           = 32;
  localparam int unsigned INDEX_WIDTH_DEFAULT = $clog2(N_DEFAULT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The index is at most n-1 because its field is exactly log2(n) bits wide,
  // so (n-1)-index can never wrap below zero. A zero operand is never shifted.
  function automatic int unsigned calc_shamt(input int unsigned index,
                                             input logic        ffo_valid,
                                             input int unsigned n);
    if (!ffo_valid) begin
      return 0;
    end
    return (n - 1) - index;
  endfunction

endpackage

// File: rtl/normalize_shifter.sv
// -----------------------------------------------------------------------------
// normalize_shifter
//   Left-justifies an operand so its leading one lands in bit N-1, using the
//   leading-one index supplied by an upstream FindFirstOne. The shift is done
//   as an iterative log-step barrel: one binary stage per clock, most
//   significant stage first, always INDEX_WIDTH stages, so the latency is
//   fixed regardless of the operand.
//
//   Ports:
//     clk_i            single clock, all state updates on posedge
//     rst_i            asynchronous active-high reset
//     in_valid_i       upstream offers data / index / ffo_valid
//     in_ready_o       block can accept (IDLE only)
//     in_data_i        operand to normalize
//     in_index_i       leading-one position from FindFirstOne
//     in_ffo_valid_i   FindFirstOne valid; 0 means the operand is zero
//     out_valid_o      result presented and held stable (DONE only)
//     out_ready_i      downstream accepts the result
//     out_data_o       normalized operand
//     out_shamt_o      applied left-shift amount
//     out_zero_o       operand was zero
//     out_norm_ok_o    out_data_o[N-1] XOR out_zero_o; low flags an index that
//                      did not match the data
// -----------------------------------------------------------------------------
module normalize_shifter
  import normalize_pkg::*;
#(
  parameter int unsigned N           = N_DEFAULT,
  parameter int unsigned INDEX_WIDTH = $clog2(N)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N-1:0]           in_data_i,
  input  logic [INDEX_WIDTH-1:0] in_index_i,
  input  logic                   in_ffo_valid_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [N-1:0]           out_data_o,
  output logic [INDEX_WIDTH-1:0] out_shamt_o,
  output logic                   out_zero_o,
  output logic                   out_norm_ok_o
);

  state_e                 state_q, state_d;
  logic [N-1:0]           data_q, data_d;
  logic [INDEX_WIDTH-1:0] shamt_q, shamt_d;
  logic [INDEX_WIDTH-1:0] stage_q, stage_d;
  logic                   zero_q, zero_d;

  logic                   accept;
  logic                   last_stage;
  logic                   stage_bit;
  logic [N-1:0]           data_stepped;

  // Handshake and stage decode shared by the controller and the datapath.
  // The stage bit is picked with a one-hot mask rather than a variable bit
  // select so the stage counter width never has to match log2(INDEX_WIDTH).
  always_comb begin
    accept       = (state_q == IDLE) && in_valid_i;
    last_stage   = (stage_q == '0);
    stage_bit    = |(shamt_q & (INDEX_WIDTH'(1) << stage_q));
    data_stepped = stage_bit ? (data_q << (32'd1 << stage_q)) : data_q;
  end

  // Controller state register. Reset drops any operation in flight straight
  // back to IDLE, so an abandoned result is never presented.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next state. SHIFT always runs all INDEX_WIDTH stages; there is
  // deliberately no early exit so downstream can rely on a fixed latency.
  // Leaving DONE goes to IDLE rather than accepting directly, which keeps
  // operations from overlapping.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i)  state_d = SHIFT;
      SHIFT:   if (last_stage)  state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Controller outputs: the two handshake flags are pure state decodes.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  // Datapath next values. On accept the operand, the shift amount and the
  // zero flag are captured and the stage counter starts at the top stage.
  // Each SHIFT cycle applies one power-of-two step; bits pushed out of the
  // top are simply lost. Everything holds outside those two cases, which is
  // what keeps the result stable under backpressure and between operations.
  always_comb begin
    data_d  = data_q;
    shamt_d = shamt_q;
    stage_d = stage_q;
    zero_d  = zero_q;
    if (accept) begin
      data_d  = in_data_i;
      shamt_d = INDEX_WIDTH'(calc_shamt(32'(in_index_i), in_ffo_valid_i, N));
      zero_d  = ~in_ffo_valid_i;
      stage_d = INDEX_WIDTH'(INDEX_WIDTH - 1);
    end else if (state_q == SHIFT) begin
      data_d = data_stepped;
      if (!last_stage) begin
        stage_d = stage_q - INDEX_WIDTH'(1);
      end
    end
  end

  // Datapath registers, cleared by reset so no stale result survives it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      shamt_q <= '0;
      stage_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      shamt_q <= shamt_d;
      stage_q <= stage_d;
      zero_q  <= zero_d;
    end
  end

  // Result outputs come straight from the holding registers. norm_ok is
  // computed rather than trusted: a wrong index leaves the top bit clear.
  always_comb begin
    out_data_o    = data_q;
    out_shamt_o   = shamt_q;
    out_zero_o    = zero_q;
    out_norm_ok_o = data_q[N-1] ^ zero_q;
  end

endmodule

// File: tb/tb_normalize_shifter.sv
// -----------------------------------------------------------------------------
// tb_normalize_shifter
//   Self-checking bench for normalize_shifter. Stimulus tasks push the
//   expected result into a queue at the accept edge; each test task pops it
//   when the DUT raises out_valid and compares inline.
// -----------------------------------------------------------------------------
module tb_normalize_shifter;
  import normalize_pkg::*;

  localparam int unsigned N       = N_DEFAULT;
  localparam int unsigned IW      = INDEX_WIDTH_DEFAULT;
  // Edges from the accept edge (counted as the first) to the edge that
  // enters DONE: the accept edge plus one edge per shift stage.
  localparam int          LATENCY = IW + 1;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [IW-1:0] shamt;
    logic          zero;
    logic          norm_ok;
  } result_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [IW-1:0] in_index;
  logic          in_ffo_valid;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [IW-1:0] out_shamt;
  logic          out_zero;
  logic          out_norm_ok;

  result_t expQ[$];
  int      total = 0;
  int      bad   = 0;

  normalize_shifter #(.N(N), .INDEX_WIDTH(IW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .in_index_i     (in_index),
    .in_ffo_valid_i (in_ffo_valid),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_shamt_o    (out_shamt),
    .out_zero_o     (out_zero),
    .out_norm_ok_o  (out_norm_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Parent-level FindFirstOne: index of the highest set bit.
  function automatic logic [IW-1:0] find_first_one(input logic [N-1:0] d);
    logic [IW-1:0] idx = '0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // Reference model: one full shift, no staging.
  function automatic result_t model(input logic [N-1:0] d, input logic [IW-1:0] idx,
                                    input logic ffo);
    result_t     r;
    int unsigned sh = calc_shamt(32'(idx), ffo, N);
    r.shamt   = IW'(sh);
    r.zero    = ~ffo;
    r.data    = d << sh;
    r.norm_ok = r.data[N-1] ^ r.zero;
    return r;
  endfunction

  function automatic result_t sample_outputs();
    result_t r;
    r.data    = out_data;
    r.shamt   = out_shamt;
    r.zero    = out_zero;
    r.norm_ok = out_norm_ok;
    return r;
  endfunction

  // Wait (bounded) for in_ready, present one operand for one edge, and queue
  // its expected result. Returns #1 after the accept edge.
  task automatic applyStimulus(input logic [N-1:0] d, input logic [IW-1:0] idx,
                               input logic ffo);
    int waitCnt = 0;
    while (in_ready !== 1'b1 && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    in_data      = d;
    in_index     = idx;
    in_ffo_valid = ffo;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expQ.push_back(model(d, idx, ffo));
  endtask

  // Bounded wait for out_valid; reports the observed result, the queued
  // expectation and the latency in edges counting the accept edge as 1.
  task automatic checkOutput(output result_t obs, output result_t exp, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < LATENCY + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = sample_outputs();
    if (expQ.size() == 0) exp = '0;
    else                  exp = expQ.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1)     begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0)    begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0)       begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (out_shamt !== '0)      begin bad++; $display("[TB] FAIL reset_out_shamt got=%0d want=0", out_shamt); end
    total++; if (out_zero !== 1'b0)     begin bad++; $display("[TB] FAIL reset_out_zero got=%b want=0", out_zero); end
    total++; if (out_norm_ok !== 1'b0)  begin bad++; $display("[TB] FAIL reset_norm_ok got=%b want=0", out_norm_ok); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Directed vectors including the largest and smallest shifts, a zero
  // operand and an index that disagrees with the data.
  task automatic test_basic();
    logic [N-1:0]  vData [6] = '{32'h0000_0001, 32'h8000_0000, 32'h0012_3456,
                                 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    logic [IW-1:0] vIdx  [6] = '{5'd0, 5'd31, 5'd20, 5'd0, 5'd5, 5'd31};
    logic          vFfo  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    result_t obs, exp;
    int      lat;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vData[i], vIdx[i], vFfo[i]);
      checkOutput(obs, exp, lat);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL basic_%0d got data=%h shamt=%0d zero=%b ok=%b want data=%h shamt=%0d zero=%b ok=%b",
                 i, obs.data, obs.shamt, obs.zero, obs.norm_ok, exp.data, exp.shamt, exp.zero, exp.norm_ok);
      end
      total++;
      if (lat !== LATENCY) begin bad++; $display("[TB] FAIL basic_latency_%0d got=%0d want=%0d", i, lat, LATENCY); end
      @(posedge clk); #1;
    end
    // Spot-check the hand-derived values from the model as well.
    applyStimulus(32'h0012_3456, 5'd20, 1'b1);
    checkOutput(obs, exp, lat);
    total++;
    if (obs.data !== 32'h91A2_B000 || obs.shamt !== 5'd11) begin
      bad++;
      $display("[TB] FAIL basic_known got data=%h shamt=%0d want data=91a2b000 shamt=11", obs.data, obs.shamt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    result_t obs, exp, now;
    int      lat;
    out_ready = 1'b0;
    applyStimulus(32'h0000_00F0, 5'd7, 1'b1);
    checkOutput(obs, exp, lat);
    total++;
    if (obs !== exp) begin bad++; $display("[TB] FAIL bp_result got=%h want=%h", obs, exp); end
    // An offered operand during DONE must not be taken.
    in_data = 32'h0000_0002; in_index = 5'd1; in_ffo_valid = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      now = sample_outputs();
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid_%0d got=%b want=1", c, out_valid); end
      total++; if (in_ready !== 1'b0)  begin bad++; $display("[TB] FAIL bp_in_ready_%0d got=%b want=0", c, in_ready); end
      total++; if (now !== exp)        begin bad++; $display("[TB] FAIL bp_stable_%0d got=%h want=%h", c, now, exp); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL bp_release_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_overlap got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    result_t obs, exp;
    int      lat;
    int      seen = 0;
    applyStimulus(32'h0000_0003, 5'd1, 1'b1);
    // Two more edges: stage counter now at 2.
    repeat (2) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL midrst_in_ready got=%b want=1", in_ready); end
    total++; if (out_data !== '0)    begin bad++; $display("[TB] FAIL midrst_data got=%h want=0", out_data); end
    total++; if (out_shamt !== '0)   begin bad++; $display("[TB] FAIL midrst_shamt got=%0d want=0", out_shamt); end
    expQ.delete();
    #2 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL midrst_stale got=%0d want=0 valid cycles", seen); end
    applyStimulus(32'h0000_0100, 5'd8, 1'b1);
    checkOutput(obs, exp, lat);
    total++;
    if (obs !== exp || exp.data !== 32'h8000_0000) begin
      bad++; $display("[TB] FAIL midrst_recover got=%h want=%h", obs, exp);
    end
    total++; if (lat !== LATENCY) begin bad++; $display("[TB] FAIL midrst_latency got=%0d want=%0d", lat, LATENCY); end
    @(posedge clk); #1;
  endtask

  // Walking one followed by random operands, all indexed by the bench's
  // FindFirstOne; norm_ok and the top bit must hold for every nonzero one.
  task automatic test_sweep();
    result_t      obs, exp;
    int           lat;
    logic [N-1:0] d;
    for (int k = 0; k < N + 3000; k++) begin
      if (k < N) d = N'(1) << k;
      else       d = $urandom() >> $urandom_range(0, 31);
      applyStimulus(d, find_first_one(d), |d);
      checkOutput(obs, exp, lat);
      total++;
      if (obs !== exp) begin
        bad++; $display("[TB] FAIL sweep_%0d in=%h got=%h want=%h", k, d, obs, exp);
      end
      total++;
      if (lat !== LATENCY) begin bad++; $display("[TB] FAIL sweep_latency_%0d got=%0d want=%0d", k, lat, LATENCY); end
      if (d != '0) begin
        total++;
        if (obs.data[N-1] !== 1'b1 || obs.norm_ok !== 1'b1) begin
          bad++; $display("[TB] FAIL sweep_norm_%0d got top=%b ok=%b want 1 1", k, obs.data[N-1], obs.norm_ok);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_index     = '0;
    in_ffo_valid = 1'b0;
    out_ready    = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
